rle_decode: RTL

Run-length decoder: the inverse of the team's `rle` encoder. It accepts one (count, value) token per handshake and expands it into `count` consecutive copies of `value` on a valid/ready output stream, at one word per clock. It sits downstream of the encoder's token channel, or of memory/links that carry encoded data, and rebuilds the original 32-bit word stream.

---
 rtl/rle_pkg.sv | 25 ++
 rtl/rle_decode.sv | 102 ++++++++++
 2 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder/decoder pair: default widths,
// the decoder state type and the (count, data) token layout.
package rle_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;

   // Decoder FSM: IDLE waits for a token, EMIT plays out the current run.
   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } rle_dec_state_t;

   // One encoded token as carried on the encoder output / link.
   typedef struct packed {
      logic [CNT_W-1:0]  count;
      logic [DATA_W-1:0] data;
   } rle_token_t;

   // A token with a zero count carries no words.
   function automatic logic rle_token_empty(input rle_token_t tok);
      return (tok.count == '0);
   endfunction

endpackage

// File: rtl/rle_decode.sv
// Run-length decoder: expands each accepted (count, value) token into
// count back-to-back copies of value on a valid/ready output stream.
//
// Handshake: both ports use valid/ready. A word or token moves on a rising
// edge where valid and ready are both high; valid never depends on ready,
// and the producer holds its payload stable until the transfer happens.
// The single combinational input-to-output path is in_ready depending on
// out_ready, which lets the next token load on the last beat of a run.
module rle_decode #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              sysres_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   import rle_pkg::*;

   rle_dec_state_t    state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  remain_q, remain_d;

   logic in_xfer;
   logic out_xfer;
   logic last_beat;
   logic tok_empty;

   // Output and handshake decode, taken from registers except in_ready.
   always_comb begin
      last_beat = (remain_q == CNT_W'(1));
      tok_empty = (in_count == '0);
      out_valid = (state_q == EMIT);
      busy      = out_valid;
      out_data  = data_q;
      out_last  = out_valid && last_beat;
      in_ready  = (state_q == IDLE) || (out_ready && last_beat);
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
   end

   // Next-state: load tokens, count down the run, chain runs without a bubble.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      remain_d = remain_q;
      unique case (state_q)
         IDLE: begin
            // Empty tokens are consumed here and simply leave state as is.
            if (in_xfer && !tok_empty) begin
               data_d   = in_data;
               remain_d = in_count;
               state_d  = EMIT;
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (!last_beat) begin
                  remain_d = remain_q - CNT_W'(1);
               end else if (in_xfer && !tok_empty) begin
                  data_d   = in_data;
                  remain_d = in_count;
               end else begin
                  // Run finished; remain_q is left at 1, it is reloaded on entry.
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any run in progress.
   always_ff @(posedge clock or negedge sysres_n) begin
      if (!sysres_n) begin
         state_q  <= IDLE;
         data_q   <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         remain_q <= remain_d;
      end
   end

   // The counter is never zero while a run is being emitted.
   a_no_zero_run: assert property (@(posedge clock) disable iff (!sysres_n)
      busy |-> (remain_q != '0));

   // A stalled word and its position in the run hold until taken.
   a_stall_hold: assert property (@(posedge clock) disable iff (!sysres_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(remain_q)));

endmodule
